// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC3 memory port: word-addressed synchronous RAM
// with a fixed wait-state count, a backdoor load port and access counters.
module lc3_mem_responder #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       memory_addr,
    input  logic [DATA_W-1:0] memory_din,
    input  logic              memWE,
    input  logic              memEN,
    output logic [DATA_W-1:0] memory_dout,
    output logic              memRDY,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t state, next_state;
    logic [3:0] cnt;

    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_din;

    logic              capture;
    logic              complete;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_we;
    logic [DATA_W-1:0] acc_din;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // With zero wait states the access completes on the capture edge, so the
    // RAM operation must use the live bus inputs rather than the latched copy.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        complete   = 1'b0;
        acc_addr   = lat_addr;
        acc_we     = lat_we;
        acc_din    = lat_din;
        unique case (state)
            S_IDLE: begin
                if (memEN) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        next_state = S_RESP;
                        complete   = 1'b1;
                        acc_addr   = memory_addr[ADDR_W-1:0];
                        acc_we     = memWE;
                        acc_din    = memory_din;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    next_state = S_RESP;
                    complete   = 1'b1;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            memory_dout <= '0;
            rd_count    <= '0;
            wr_count    <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                cnt <= WAIT_LOAD;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (complete) begin
                if (acc_we) begin
                    wr_count <= wr_count + 32'd1;
                end else begin
                    rd_count    <= rd_count + 32'd1;
                    memory_dout <= mem[acc_addr];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            lat_addr <= memory_addr[ADDR_W-1:0];
            lat_we   <= memWE;
            lat_din  <= memory_din;
        end
    end

    // Backdoor write is issued last so it wins an address collision; RAM is
    // deliberately left out of reset so preloaded programs survive.
    always_ff @(posedge clk) begin
        if (rst && complete && acc_we) begin
            mem[acc_addr] <= acc_din;
        end
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign memRDY = (state == S_RESP);
    assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: three instances cover 2 wait states,
// 0 wait states and an 8-bit address space (aliasing).
module tb_lc3_mem_responder;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] din;
        logic        hold;
        logic        ld;
        logic [15:0] ld_addr;
        logic [15:0] ld_data;
        logic [15:0] exp_dout;
        int unsigned exp_rd;
        int unsigned exp_wr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic [15:0] addr  [3];
    logic [15:0] din   [3];
    logic        we    [3];
    logic        en    [3];
    logic [15:0] dout  [3];
    logic        rdy   [3];
    logic        ld_en [3];
    logic [15:0] ld_a  [3];
    logic [15:0] ld_d  [3];
    logic        busy  [3];
    logic [31:0] rdc   [3];
    logic [31:0] wrc   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3_mem_responder #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst[0]), .memory_addr(addr[0]), .memory_din(din[0]),
        .memWE(we[0]), .memEN(en[0]), .memory_dout(dout[0]), .memRDY(rdy[0]),
        .ld_en(ld_en[0]), .ld_addr(ld_a[0]), .ld_data(ld_d[0]),
        .busy(busy[0]), .rd_count(rdc[0]), .wr_count(wrc[0])
    );

    lc3_mem_responder #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst[1]), .memory_addr(addr[1]), .memory_din(din[1]),
        .memWE(we[1]), .memEN(en[1]), .memory_dout(dout[1]), .memRDY(rdy[1]),
        .ld_en(ld_en[1]), .ld_addr(ld_a[1]), .ld_data(ld_d[1]),
        .busy(busy[1]), .rd_count(rdc[1]), .wr_count(wrc[1])
    );

    lc3_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) u_a8 (
        .clk(clk), .rst(rst[2]), .memory_addr(addr[2]), .memory_din(din[2]),
        .memWE(we[2]), .memEN(en[2]), .memory_dout(dout[2]), .memRDY(rdy[2]),
        .ld_en(ld_en[2]), .ld_addr(ld_a[2][7:0]), .ld_data(ld_d[2]),
        .busy(busy[2]), .rd_count(rdc[2]), .wr_count(wrc[2])
    );

    function automatic int unsigned wc(input int k);
        return (k == 1) ? 0 : 2;
    endfunction

    function automatic vec_t mk(input logic we_i, input logic [15:0] a, input logic [15:0] d,
                                input logic hold, input logic ld, input logic [15:0] la,
                                input logic [15:0] lv, input logic [15:0] ed,
                                input int unsigned er, input int unsigned ew);
        vec_t v;
        v.we = we_i; v.addr = a; v.din = d; v.hold = hold; v.ld = ld;
        v.ld_addr = la; v.ld_data = lv; v.exp_dout = ed; v.exp_rd = er; v.exp_wr = ew;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic load(input int k, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en[k] = 1'b1; ld_a[k] = a; ld_d[k] = d;
        @(negedge clk);
        ld_en[k] = 1'b0;
    endtask

    // One bus access; an optional backdoor write lands on the completion edge.
    task automatic txn(input int k, input vec_t v, input string nm);
        int unsigned lat;
        @(negedge clk);
        en[k] = 1'b1; we[k] = v.we; addr[k] = v.addr; din[k] = v.din;
        @(negedge clk);
        lat = 1;
        if (!v.hold) en[k] = 1'b0;
        while (!rdy[k] && lat < 40) begin
            if (v.ld && lat == wc(k)) begin
                ld_en[k] = 1'b1; ld_a[k] = v.ld_addr; ld_d[k] = v.ld_data;
            end
            @(negedge clk);
            ld_en[k] = 1'b0;
            lat++;
        end
        en[k] = 1'b0;
        chk({nm, "_latency"}, lat, wc(k) + 1);
        chk({nm, "_dout"}, 32'(dout[k]), 32'(v.exp_dout));
        chk({nm, "_rd_count"}, rdc[k], v.exp_rd);
        chk({nm, "_wr_count"}, wrc[k], v.exp_wr);
        @(negedge clk);
        chk({nm, "_rdy_pulse"}, 32'(rdy[k]), 32'd0);
        chk({nm, "_busy_after"}, 32'(busy[k]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[12];
        vt[0]  = mk(1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 1, 0);
        vt[1]  = mk(1'b1, 16'h3001, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 1, 1);
        vt[2]  = mk(1'b0, 16'h3001, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 2, 1);
        vt[3]  = mk(1'b1, 16'h3002, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 2, 2);
        vt[4]  = mk(1'b0, 16'h3002, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0F0F, 3, 2);
        vt[5]  = mk(1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 4, 2);
        vt[6]  = mk(1'b1, 16'h2000, 16'hAAAA, 1'b0, 1'b1, 16'h2000, 16'h1111, 16'h1234, 4, 3);
        vt[7]  = mk(1'b0, 16'h2000, 16'h0000, 1'b0, 1'b1, 16'h2000, 16'h3333, 16'h1111, 5, 3);
        vt[8]  = mk(1'b0, 16'h2000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h3333, 6, 3);
        vt[9]  = mk(1'b1, 16'h2001, 16'h5A5A, 1'b0, 1'b1, 16'h2002, 16'hC3C3, 16'h3333, 6, 4);
        vt[10] = mk(1'b0, 16'h2001, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h5A5A, 7, 4);
        vt[11] = mk(1'b0, 16'h2002, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hC3C3, 8, 4);

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; en[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; din[k] = '0;
            ld_en[k] = 1'b0; ld_a[k] = '0; ld_d[k] = '0;
        end

        // Preload while held in reset.
        load(0, 16'h3000, 16'h1234);
        load(0, 16'h4000, 16'h5555);
        for (int i = 0; i < 5; i++) load(1, 16'(i), 16'h0A00 + 16'(i));

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d_rdy", k), 32'(rdy[k]), 32'd0);
            chk($sformatf("rst%0d_dout", k), 32'(dout[k]), 32'd0);
            chk($sformatf("rst%0d_busy", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst%0d_rd", k), rdc[k], 32'd0);
            chk($sformatf("rst%0d_wr", k), wrc[k], 32'd0);
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;

        for (int i = 0; i < 12; i++) txn(0, vt[i], $sformatf("v%0d", i));

        // Reset in the middle of a write's wait states drops it entirely.
        @(negedge clk);
        en[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h4000; din[0] = 16'h9999;
        @(negedge clk);
        en[0] = 1'b0;
        chk("midrst_busy_wait", 32'(busy[0]), 32'd1);
        rst[0] = 1'b0;
        @(negedge clk);
        chk("midrst_rdy", 32'(rdy[0]), 32'd0);
        chk("midrst_dout", 32'(dout[0]), 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_rd", rdc[0], 32'd0);
        chk("midrst_wr", wrc[0], 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (4) begin
                @(negedge clk);
                seen = seen | rdy[0];
            end
            chk("midrst_no_rdy", 32'(seen), 32'd0);
        end
        rst[0] = 1'b1;
        txn(0, mk(1'b0, 16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h5555, 1, 0), "midrst_ram");

        // Zero wait states, memEN held: one completion every second cycle.
        @(negedge clk);
        en[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("w0_c%0d_rdy", c), 32'(rdy[1]), 32'((c % 2) == 0));
            chk($sformatf("w0_c%0d_busy", c), 32'(busy[1]), 32'((c % 2) == 0));
            if ((c % 2) == 0) begin
                chk($sformatf("w0_c%0d_dout", c), 32'(dout[1]), 32'h0A00 + 32'(c / 2));
                addr[1] = 16'(c / 2 + 1);
            end
            if (c == 9) en[1] = 1'b0;
        end
        @(negedge clk);
        chk("w0_rd_count", rdc[1], 32'd5);
        chk("w0_idle", 32'(busy[1]), 32'd0);

        // 8-bit address space: 0x01FF and 0x00FF are the same word.
        txn(2, mk(1'b1, 16'h01FF, 16'h7E57, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0000, 0, 1), "alias_wr");
        txn(2, mk(1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h7E57, 1, 1), "alias_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
